// File: rtl/neuron_input_loader_if.sv
// Handshake and bus bundle between the input stream, the loader, the dot-product
// calculator and the result consumer.
interface neuron_input_loader_if #(
   parameter int unsigned N = 784,
   parameter int unsigned W = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_value;
   logic [W-1:0]   in_weight;
   logic [N*W-1:0] values_bus;
   logic [N*W-1:0] weights_bus;
   logic           calc_run;
   logic [W-1:0]   calc_out;
   logic [W-1:0]   result;
   logic           result_valid;
   logic           result_ready;
   logic           busy;

   // Loader side: consumes beats and calculator output, produces buses and result.
   modport slave (
      input  in_valid, in_value, in_weight, calc_out, result_ready,
      output in_ready, values_bus, weights_bus, calc_run, result, result_valid, busy
   );

   // Environment side: producer of beats, calculator and result consumer.
   modport master (
      output in_valid, in_value, in_weight, calc_out, result_ready,
      input  in_ready, values_bus, weights_bus, calc_run, result, result_valid, busy
   );
endinterface

// File: rtl/neuron_input_loader.sv
// Streaming front end for the wide dot-product calculator: packs (value, weight)
// beats into the calculator buses, runs the calculator pipeline until it settles,
// then holds the captured result on a valid/ready port.
module neuron_input_loader #(
   parameter int unsigned N            = 784,
   parameter int unsigned W            = 16,
   parameter int unsigned CALC_LATENCY = 11
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   neuron_input_loader_if.slave  bus_io
);

   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CntW = (CALC_LATENCY > 0) ? $clog2(CALC_LATENCY + 1) : 1;

   typedef enum logic [1:0] {StLoad, StRun, StHold} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic [W-1:0]    result_q, result_d;
   logic            result_valid_q, result_valid_d;
   logic [N*W-1:0]  values_q;
   logic [N*W-1:0]  weights_q;
   logic            in_ready;
   logic            accept;

   // Beats are only taken in LOAD, and never while reset is held.
   always_comb begin
      in_ready = (state_q == StLoad) && !reset_i;
      accept   = in_ready && bus_io.in_valid;
   end

   // Next-state logic for the load / run / hold sequence.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      wait_cnt_d     = wait_cnt_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               if (idx_q == IdxW'(N - 1)) begin
                  idx_d      = '0;
                  wait_cnt_d = '0;
                  state_d    = StRun;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StRun: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            // The last run edge lets the calculator output settle on stable buses.
            if (wait_cnt_q == CntW'(CALC_LATENCY)) begin
               result_d       = bus_io.calc_out;
               result_valid_d = 1'b1;
               state_d        = StHold;
            end
         end
         StHold: begin
            if (result_valid_q && bus_io.result_ready) begin
               result_valid_d = 1'b0;
               state_d        = StLoad;
            end
         end
         default: begin
            state_d = StLoad;
         end
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= StLoad;
         idx_q          <= '0;
         wait_cnt_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         wait_cnt_q     <= wait_cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   // Element-wise bus write; untouched elements keep the previous load's contents.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         values_q  <= '0;
         weights_q <= '0;
      end else if (accept) begin
         values_q[W * int'(idx_q) +: W]  <= bus_io.in_value;
         weights_q[W * int'(idx_q) +: W] <= bus_io.in_weight;
      end
   end

   // Output drive.
   always_comb begin
      bus_io.in_ready     = in_ready;
      bus_io.calc_run     = (state_q == StRun);
      bus_io.values_bus   = values_q;
      bus_io.weights_bus  = weights_q;
      bus_io.result       = result_q;
      bus_io.result_valid = result_valid_q;
      bus_io.busy         = (state_q != StLoad) || (idx_q != '0);
   end

endmodule

// File: tb/tb_neuron_input_loader.sv
// Bench for neuron_input_loader: a behavioural calculator pipeline, a result
// scoreboard and directed load/run/hold/reset sequences.
module tb_neuron_input_loader;

   localparam int unsigned N = 784;
   localparam int unsigned W = 16;
   localparam int unsigned L = 11;

   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_exp;
   logic         rv_prev = 1'b0;
   logic [31:0]  stage_q [L];

   neuron_input_loader_if #(.N(N), .W(W)) bus_if ();

   neuron_input_loader #(
      .N            (N),
      .W            (W),
      .CALC_LATENCY (L)
   ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_io  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dot(input logic [N*W-1:0] v, input logic [N*W-1:0] w);
      logic [31:0] acc;
      acc = '0;
      for (int k = 0; k < N; k++) acc += 32'(v[k*W +: W]) * 32'(w[k*W +: W]);
      return acc;
   endfunction

   // Calculator model: L register stages advancing only while calc_run is high.
   initial for (int i = 0; i < L; i++) stage_q[i] = '0;
   always @(posedge clk) begin
      if (bus_if.calc_run) begin
         stage_q[0] <= dot(bus_if.values_bus, bus_if.weights_bus);
         for (int i = 1; i < L; i++) stage_q[i] <= stage_q[i-1];
      end
   end
   assign bus_if.calc_out = stage_q[L-1][31:16];

   // Scoreboard: pop an expected result on each rising result_valid.
   always @(negedge clk) begin
      rv_prev <= bus_if.result_valid;
      if (bus_if.result_valid && !rv_prev) begin
         if (exp_q.size() == 0) check_eq("sb_unexpected_result", 1, 0);
         else check_eq("sb_result", bus_if.result, exp_q.pop_front());
      end
   end

   function automatic logic [W-1:0] beat_value(input int mode, input int k);
      case (mode)
         1:       return W'(k);
         2:       return 16'h0200;
         default: return 16'h0100;
      endcase
   endfunction

   function automatic logic [W-1:0] beat_weight(input int mode, input int k);
      case (mode)
         1:       return 16'hFFFF - W'(k);
         default: return 16'h0100;
      endcase
   endfunction

   // Drive n_beats beats; returns just after the edge that accepts the last one.
   task automatic load(input int mode, input int n_beats, input bit gaps);
      logic [31:0]  acc;
      logic [W-1:0] v;
      logic [W-1:0] w;
      int           c;
      acc = '0;
      c   = 0;
      for (int k = 0; k < n_beats; k++) begin
         if (gaps && (c % 3 == 2)) begin
            @(negedge clk);
            bus_if.in_valid  = 1'b0;
            bus_if.in_value  = 16'hDEAD;
            bus_if.in_weight = 16'hBEEF;
            c++;
         end
         @(negedge clk);
         if (k == 0) check_eq("load_ready_first", bus_if.in_ready, 1);
         if (k == N - 1) check_eq("calc_run_before_e0", bus_if.calc_run, 0);
         v = beat_value(mode, k);
         w = beat_weight(mode, k);
         bus_if.in_valid  = 1'b1;
         bus_if.in_value  = v;
         bus_if.in_weight = w;
         acc += 32'(v) * 32'(w);
         c++;
      end
      @(posedge clk);
      if (n_beats == N) begin
         last_exp = acc[31:16];
         exp_q.push_back(acc[31:16]);
      end
   endtask

   // Follow the run from E0; ends at the negedge after E(L+1).
   task automatic wait_run();
      for (int t = 1; t <= L + 2; t++) begin
         @(negedge clk);
         if (t == 1) bus_if.in_valid = 1'b0;
         if (t <= L + 1) begin
            check_eq("run_calc_run", bus_if.calc_run, 1);
            check_eq("run_in_ready", bus_if.in_ready, 0);
         end
         if (t == L + 1) check_eq("rv_before_last_edge", bus_if.result_valid, 0);
         if (t == L + 2) begin
            check_eq("rv_after_last_edge", bus_if.result_valid, 1);
            check_eq("calc_run_off", bus_if.calc_run, 0);
            check_eq("hold_busy", bus_if.busy, 1);
         end
      end
   endtask

   task automatic check_buses(input int mode, input string tag);
      for (int k = 0; k < N; k++) begin
         check_eq({tag, "_value"}, bus_if.values_bus[k*W +: W], beat_value(mode, k));
         check_eq({tag, "_weight"}, bus_if.weights_bus[k*W +: W], beat_weight(mode, k));
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_in_ready"}, bus_if.in_ready, 0);
      check_eq({tag, "_calc_run"}, bus_if.calc_run, 0);
      check_eq({tag, "_result_valid"}, bus_if.result_valid, 0);
      check_eq({tag, "_result"}, bus_if.result, 0);
      check_eq({tag, "_values_zero"}, (bus_if.values_bus == '0), 1);
      check_eq({tag, "_weights_zero"}, (bus_if.weights_bus == '0), 1);
      check_eq({tag, "_busy"}, bus_if.busy, 0);
   endtask

   initial begin
      reset               = 1'b1;
      bus_if.in_valid     = 1'b0;
      bus_if.in_value     = '0;
      bus_if.in_weight    = '0;
      bus_if.result_ready = 1'b1;

      // Asynchronous reset before any clock edge.
      #3;
      check_reset_state("por");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("por_release_ready", bus_if.in_ready, 1);
      check_eq("por_release_busy", bus_if.busy, 0);

      // Full-scale sum.
      load(0, N, 1'b0);
      wait_run();
      @(negedge clk);
      check_eq("ack_rv_clear", bus_if.result_valid, 0);
      check_eq("ack_ready", bus_if.in_ready, 1);
      check_eq("ack_busy", bus_if.busy, 0);

      // Ordering under gaps, then result backpressure.
      bus_if.result_ready = 1'b0;
      load(1, N, 1'b1);
      wait_run();
      check_buses(1, "order");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus_if.in_valid  = 1'b1;
         bus_if.in_value  = 16'h5555;
         bus_if.in_weight = 16'hAAAA;
         check_eq("bp_result_stable", bus_if.result, last_exp);
         check_eq("bp_result_valid", bus_if.result_valid, 1);
         check_eq("bp_in_ready", bus_if.in_ready, 0);
         check_eq("bp_calc_run", bus_if.calc_run, 0);
      end
      @(negedge clk);
      check_eq("bp_no_accept_value", bus_if.values_bus[0 +: W], 16'h0000);
      check_eq("bp_no_accept_weight", bus_if.weights_bus[0 +: W], 16'hFFFF);
      bus_if.in_valid     = 1'b0;
      bus_if.result_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_rv", bus_if.result_valid, 0);
      check_eq("bp_release_ready", bus_if.in_ready, 1);

      // Reset mid-load after 400 accepted beats.
      load(2, 400, 1'b0);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      check_eq("midload_busy", bus_if.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("midload_reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("midload_release_ready", bus_if.in_ready, 1);
      check_eq("midload_release_busy", bus_if.busy, 0);
      load(0, N, 1'b0);
      wait_run();

      // Back-to-back runs with full overwrite.
      load(0, N, 1'b0);
      wait_run();
      check_buses(0, "b2b_run1");
      load(2, N, 1'b0);
      wait_run();
      check_buses(2, "b2b_run2");
      @(negedge clk);
      check_eq("final_ready", bus_if.in_ready, 1);

      check_eq("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/neuron_input_loader.md
# neuron_input_loader

Streaming front end for the 784-input dot-product calculator. It accepts (value, weight) pairs one per beat over a valid/ready handshake and packs them into the calculator's wide `values_bus`/`weights_bus`. Once all N pairs are loaded it holds both buses stable and keeps the calculator's run enable high until the pipelined sum has settled. It then captures the calculator's 16-bit output and presents it on a valid/ready result port.

## Interface
- `N`, default 784: elements per dot product.
- `W`, default 16: element width.
- `CALC_LATENCY`, default 11: number of register stages between the calculator's bus inputs and its output.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  loader accepts a beat.
- `in_value`  in  W  element value.
- `in_weight`  in  W  element weight.
- `values_bus`  out  N*W  element k at bits [k*W +: W].
- `weights_bus`  out  N*W  same packing as `values_bus`.
- `calc_run`  out  1  calculator pipeline advance enable.
- `calc_out`  in  W  calculator result (sum bits [31:16]).
- `result`  out  W  captured dot-product result.
- `result_valid`  out  1  `result` is available.
- `result_ready`  in  1  consumer accepts `result`.
- `busy`  out  1  a load is in progress, or a run or result is pending.

## Operation
- There are three states: LOAD, RUN and HOLD. `idx` has width clog2(N) and `wait_cnt` has width clog2(CALC_LATENCY+1).
- Reset (asynchronous) sets: state LOAD, `idx`=0, `wait_cnt`=0, both buses all-zero, `result`=0, `result_valid`=0.
- While reset is asserted, `in_ready`=0 and `calc_run`=0.
- LOAD:
  - `in_ready`=1, `calc_run`=0.
  - Each beat with `in_valid`&&`in_ready` writes `in_value` into element `idx` of `values_bus` and `in_weight` into element `idx` of `weights_bus`, then increments `idx`.
  - The beat at `idx`=N-1 sets `idx`=0 and `wait_cnt`=0, and the state becomes RUN.
- RUN:
  - `in_ready`=0, `calc_run`=1, and both buses are frozen.
  - `wait_cnt` increments once per cycle.
  - At the edge ending the cycle with `wait_cnt`==CALC_LATENCY: `result`<=`calc_out`, `result_valid`<=1, and the state becomes HOLD.
- HOLD:
  - `in_ready`=0, `calc_run`=0, `result` is stable, and the buses keep their loaded contents.
  - `result_valid`&&`result_ready` clears `result_valid` and returns the state to LOAD.
- Input rules:
  - Beats offered outside LOAD are not accepted. `in_valid` is ignored there.
  - Gaps in `in_valid` during LOAD simply stall `idx`.
- `busy` = (state != LOAD) || (`idx` != 0).
- Loads do not overlap runs. Elements are written in strict arrival order, with no reordering and no skipping.
- Buses are overwritten element by element by the next load; they are not cleared between loads.
- Reset mid-operation, in any state, aborts the load, run or pending result. The buses return to zero and a full N-beat reload is required.

## Timing
- Input throughput: one beat per cycle in LOAD.
- Call the edge that accepts beat N-1 E0. `calc_run` is high during the cycles following E0 through E(CALC_LATENCY+1).
- The calculator therefore sees stable buses on CALC_LATENCY+1 run edges. This flushes any stale pipeline contents.
- `result_valid` rises after edge E(CALC_LATENCY+1), which is E12 by default.
- Minimum time from `result_valid`&&`result_ready` to the next `in_ready`=1 is one cycle (after that edge).
- Minimum period per dot product: N + CALC_LATENCY + 2 cycles.

## Test plan
- Reset check: assert `reset` asynchronously, away from a clock edge.
  - Required immediately: `in_ready`=0, `calc_run`=0, `result_valid`=0, `result`=0, buses zero.
  - After release: `in_ready`=1, `busy`=0.
- Full-scale sum: 784 beats, all `in_value`=16'h0100 and `in_weight`=16'h0100, with the team calculator attached.
  - Required: `calc_run` high for exactly 12 cycles.
  - `result_valid` rises after E12.
  - `result`=16'h0310 (784·0x10000 = 0x03100000).
- Ordering under gaps: `in_value`=k and `in_weight`=16'hFFFF-k, with `in_valid` deasserted on every third cycle.
  - Required: `values_bus[k*16 +: 16]`==k and `weights_bus[k*16 +: 16]`==16'hFFFF-k for all k.
  - `idx` does not advance on gap cycles.
- Result backpressure: hold `result_ready`=0 for 20 cycles after `result_valid` rises.
  - Required: `result` is stable, and `in_ready`=0 and `calc_run`=0 throughout.
  - Offering `in_valid` during the hold is not accepted.
  - Then assert `result_ready` for 1 cycle. Required: `result_valid`=0 and `in_ready`=1 on the next cycle.
- Reset mid-load: assert `reset` after 400 accepted beats.
  - Required: buses zero, `busy`=0.
  - A subsequent full 784-beat load of all 16'h0100 pairs yields `result`=16'h0310.
- Back-to-back runs: run 1 loads all 16'h0100 pairs; run 2 loads `in_value`=16'h0200 and `in_weight`=16'h0100.
  - Required: `result` = 16'h0310, then 16'h0620.
  - Run 2's elements fully overwrite run 1's.
